// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
//   tx_state_t  : transmitter frame states
//   UART_DATA_W : payload width of one character
//   baud_div()  : clocks per bit for a given clock and line rate (truncated)
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty); dout shows the head entry
//   full/empty : derived from count
//   count      : entries currently held, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset: empty/full gate every access.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 (optional parity) UART transmitter.
//   clk, reset        : clock, asynchronous active-low reset
//   i_data, i_valid   : byte push, accepted on a rising edge with i_valid && o_ready
//   o_ready           : FIFO not full
//   o_txd             : registered serial line, idle high, LSB first
//   o_busy            : a frame is being shifted
//   o_count           : bytes waiting in the FIFO (not counting the byte in flight)
//   o_state           : current FSM state, for observation
// Handshake: a transfer happens exactly on a rising edge where i_valid and
// o_ready are both high; i_valid while o_ready is low drops the byte.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH      = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_txd,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [2:0]             o_state
);

  localparam int   DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int   CW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic P_ODD = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  logic [2:0]             r_state;
  logic [CW-1:0]          r_baud;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_par;
  logic                   r_txd;

  logic [UART_DATA_W-1:0] w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_bit_end;
  logic                   w_pop;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (i_valid),
    .pop   (w_pop),
    .din   (i_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (o_count)
  );

  assign w_bit_end = (r_baud == CW'(DIV - 1));
  // A frame starts either from idle or straight out of the last stop clock,
  // which is what makes consecutive frames gap-free.
  assign w_pop     = !w_empty && ((r_state == S_IDLE) ||
                                  (r_state == S_STOP && w_bit_end));

  assign o_ready = !w_full;
  assign o_busy  = (r_state != S_IDLE);
  assign o_txd   = r_txd;
  assign o_state = r_state;

  // r_txd is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and never decodes combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_shift <= w_head;
      r_par   <= (^w_head) ^ P_ODD;
      r_baud  <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_baud <= r_baud + CW'(1);
      end else begin
        r_baud <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_txd   <= r_shift[0];
          end
          S_DATA: begin
            r_shift <= {1'b0, r_shift[UART_DATA_W-1:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_txd   <= r_par;
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_txd <= r_shift[1];
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
          default: begin
            // End of stop with nothing queued (the queued case is w_pop).
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 8;
  localparam int FRAME    = 10 * DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_valid_p = 1'b0;

  always #5 clk = ~clk;

  logic       o_ready, o_txd, o_busy;
  logic [3:0] o_count;
  logic [2:0] o_state;

  logic       pe_ready, pe_txd, pe_busy;
  logic [3:0] pe_count;
  logic [2:0] pe_state;
  logic       po_ready, po_txd, po_busy;
  logic [3:0] po_count;
  logic [2:0] po_state;

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH),
                     .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_txd(o_txd), .o_busy(o_busy), .o_count(o_count),
    .o_state(o_state));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH),
                     .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid_p),
    .o_ready(pe_ready), .o_txd(pe_txd), .o_busy(pe_busy), .o_count(pe_count),
    .o_state(pe_state));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH),
                     .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid_p),
    .o_ready(po_ready), .o_txd(po_txd), .o_busy(po_busy), .o_count(po_count),
    .o_state(po_state));

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes waiting, the byte on the line and how far into its frame we are.
  logic [7:0] exp_q[$];
  logic [7:0] sent_log[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_busy = 1'b0;
  int         m_t = 0;
  bit         m_can_push, m_do_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      sent_log.delete();
      m_busy = 1'b0;
      m_t    = 0;
    end else begin
      m_can_push = (exp_q.size() < DEPTH);
      m_do_pop   = (exp_q.size() != 0) && (!m_busy || m_t == FRAME - 1);
      if (m_busy) begin
        m_t++;
        if (m_t == FRAME) m_busy = 1'b0;
      end
      if (m_do_pop) begin
        m_cur  = exp_q.pop_front();
        m_busy = 1'b1;
        m_t    = 0;
      end
      if (i_valid && m_can_push) begin
        exp_q.push_back(i_data);
        sent_log.push_back(i_data);
      end
    end
  end

  // Line level for bit slot k = t/DIV: start, D0..D7, stop.
  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_t / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  bit chk_en = 1'b1;
  int busy_cycles = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd",   {31'd0, o_txd},   {31'd0, exp_txd()});
      check("busy",  {31'd0, o_busy},  {31'd0, m_busy});
      check("count", {28'd0, o_count}, exp_q.size());
      check("ready", {31'd0, o_ready}, (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
    end
    if (o_busy) busy_cycles++;
  end

  // Independent line decoder: samples each bit in its middle.
  logic [7:0] rx_log[$];
  logic [7:0] rx_sh = 8'h00;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_k = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (o_txd == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        rx_k = rx_cnt / DIV;
        if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = o_txd;
        if (rx_k == 9) begin
          rx_log.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All stimulus changes 1 time unit after a rising edge.
  task automatic push_byte(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0 || o_busy) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= max_cyc) check("idle_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rx_log.delete();
    sent_log.delete();
    busy_cycles = 0;
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_nbytes"}, rx_log.size(), sent_log.size());
    for (int i = 0; i < rx_log.size() && i < sent_log.size(); i++)
      check({tag, "_byte"}, {24'd0, rx_log[i]}, {24'd0, sent_log[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pl[$];
  int         cnt_e, cnt_o, n;
  logic       par_e, par_o;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",   {31'd0, o_txd},   32'd1);
    check("rst_busy",  {31'd0, o_busy},  32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_count", {28'd0, o_count}, 32'd0);
    check("rst_state", {29'd0, o_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---------------- single byte 0xA5 ----------------
    clear_logs();
    push_byte(8'hA5);
    check("a5_count_after_push", {28'd0, o_count}, 32'd1);
    check("a5_txd_after_push",   {31'd0, o_txd},   32'd1);
    @(posedge clk); #1;
    check("a5_txd_start",  {31'd0, o_txd},   32'd0);
    check("a5_busy_start", {31'd0, o_busy},  32'd1);
    check("a5_count_pop",  {28'd0, o_count}, 32'd0);
    wait_idle(400);
    check("a5_busy_len", busy_cycles, 32'd160);
    check("a5_nbytes", rx_log.size(), 32'd1);
    if (rx_log.size() > 0) check("a5_byte", {24'd0, rx_log[0]}, 32'hA5);

    // ---------------- three back-to-back ----------------
    clear_logs();
    i_valid = 1'b1;
    i_data = 8'h00; @(posedge clk); #1;
    i_data = 8'hFF; @(posedge clk); #1;
    i_data = 8'h3C; @(posedge clk); #1;
    i_valid = 1'b0;
    wait_idle(800);
    check("b2b_busy_len", busy_cycles, 32'd480);
    compare_rx("b2b");

    // ---------------- overflow ----------------
    clear_logs();
    pl.delete();
    i_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      i_data = 8'($urandom);
      pl.push_back(i_data);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("ovf_ready", {31'd0, o_ready}, 32'd0);
    check("ovf_count", {28'd0, o_count}, 32'd8);
    wait_idle(9 * FRAME + 200);
    check("ovf_nframes", rx_log.size(), 32'd9);
    for (int i = 0; i < rx_log.size() && i < 9; i++)
      check("ovf_byte", {24'd0, rx_log[i]}, {24'd0, pl[i]});

    // ---------------- parity ----------------
    i_data = 8'h07;
    i_valid_p = 1'b1;
    @(posedge clk); #1;
    i_valid_p = 1'b0;
    cnt_e = 0; cnt_o = 0; par_e = 1'bx; par_o = 1'bx;
    repeat (220) begin
      @(negedge clk);
      if (pe_busy) begin
        if (cnt_e == 9 * DIV + DIV / 2) par_e = pe_txd;
        cnt_e++;
      end
      if (po_busy) begin
        if (cnt_o == 9 * DIV + DIV / 2) par_o = po_txd;
        cnt_o++;
      end
    end
    @(posedge clk); #1;
    check("par_even_bit", {31'd0, par_e}, 32'd1);
    check("par_even_len", cnt_e, 32'd176);
    check("par_odd_bit",  {31'd0, par_o}, 32'd0);
    check("par_odd_len",  cnt_o, 32'd176);

    // ---------------- reset mid-frame ----------------
    clear_logs();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    n = 0;
    while (!(m_busy && m_t == 5 * DIV + 3) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("rst_mid_timeout", 32'd0, 32'd1);
    check("rst_mid_count_before", {28'd0, o_count}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_txd",   {31'd0, o_txd},   32'd1);
    check("rst_mid_count", {28'd0, o_count}, 32'd0);
    check("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_log.delete();
    busy_cycles = 0;
    repeat (300) @(posedge clk);
    #1;
    check("rst_mid_no_frames", rx_log.size(), 32'd0);
    check("rst_mid_no_busy",   busy_cycles, 32'd0);
    check("rst_mid_count_after", {28'd0, o_count}, 32'd0);
    check("rst_mid_ready_after", {31'd0, o_ready}, 32'd1);

    // ---------------- push and pop on the same edge ----------------
    clear_logs();
    pl.delete();
    for (int i = 0; i < 8; i++) begin
      pl.push_back(8'($urandom));
      push_byte(pl[i]);
    end
    n = 0;
    while (!(m_busy && m_t == FRAME - 1) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("pp_timeout", 32'd0, 32'd1);
    check("pp_count_before", {28'd0, o_count}, 32'd7);
    pl.push_back(8'($urandom));
    push_byte(pl[8]);
    check("pp_count_same", {28'd0, o_count}, 32'd7);
    check("pp_ready_same", {31'd0, o_ready}, 32'd1);
    wait_idle(9 * FRAME + 200);
    check("pp_nbytes", rx_log.size(), 32'd9);
    for (int i = 0; i < rx_log.size() && i < 9; i++)
      check("pp_byte", {24'd0, rx_log[i]}, {24'd0, pl[i]});

    // ---------------- random traffic ----------------
    clear_logs();
    for (int c = 0; c < 1200; c++) begin
      i_valid = ($urandom_range(0, 99) < 6);
      i_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    wait_idle(DEPTH * FRAME + 2 * FRAME);
    compare_rx("rand");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
